quad_pixel_fetch_unit: RTL and testbench
========================================

Name: quad_pixel_fetch_unit

Overview:
- Responder side of the bilinear datapath's 2x2-neighbourhood fetch handshake.
- Accepts one (xi, yi, fx, fy) request and reads the four neighbour pixels from the shared wide input memory. That memory is 32-bit words, 4 pixels per word, synchronous read, 2 read ports.
- Holds tl/tr/bl/br and the fractions stable until the requester signals consumption.
- Serves the SIMD4 bilinear engine, one lane at a time.

Parameters:
- ADDR_W, 10: word-address width of the input memory.
- IMG_WIDTH, 64: source image width in pixels; must be a multiple of 4 and at least 4.
- IMG_HEIGHT, 64: source image height in pixels; must be at least 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe, sampled only when req_ready=1.
- req_xi_base  in  16  left neighbour x.
- req_yi_base  in  16  top neighbour y.
- req_fx_q  in  8  x fraction, Q0.8.
- req_fy_q  in  8  y fraction, Q0.8.
- req_ready  out  1  high only in IDLE (combinational from state).
- data_valid  out  1  registered; result outputs valid.
- pixel_tl  out  8  pixel (x, y).
- pixel_tr  out  8  pixel (x+1, y).
- pixel_bl  out  8  pixel (x, y+1).
- pixel_br  out  8  pixel (x+1, y+1).
- frac_x  out  8  latched req_fx_q.
- frac_y  out  8  latched req_fy_q.
- data_consumed  in  1  requester has taken the result.
- mem_raddr0  out  ADDR_W  registered word address, row y.
- mem_rdata0  in  32  word read via port 0, valid one cycle after its address.
- mem_raddr1  out  ADDR_W  registered word address, row y+1.
- mem_rdata1  in  32  word read via port 1.
- rd_word_count  out  32  total memory words read since reset.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - data_valid, all pixel outputs, frac outputs, mem_raddr0/1 and rd_word_count are 0.
  - Applies mid-operation; any in-flight request is discarded.
- Memory layout:
  - Linear index = y*IMG_WIDTH + x.
  - Word address = index>>2, truncated to ADDR_W (wraps mod 2^ADDR_W).
  - Byte k = bits [8k+7:8k] holds pixel x with x[1:0]=k.
- Accept (IDLE, req_valid=1):
  - Clamp x to IMG_WIDTH-2 if xi > IMG_WIDTH-2; clamp y to IMG_HEIGHT-2 if yi > IMG_HEIGHT-2. Fractions are passed through unchanged.
  - Latch x, y, fx, fy.
  - Load mem_raddr0 = word(x, y) and mem_raddr1 = mem_raddr0 + IMG_WIDTH/4.
  - Go to WAIT0.
  - req_valid outside IDLE is ignored, not queued.
- States:
  - IDLE -> WAIT0 on accept.
  - WAIT0 -> CAP0 unconditionally.
  - CAP0: capture byte x[1:0] of rdata0/rdata1 into tl/bl.
    - Non-straddle (x[1:0] != 3): also capture byte x[1:0]+1 into tr/br, then -> VALID.
    - Straddle (x[1:0] = 3): increment both mem_raddr by 1, then -> WAIT1.
  - WAIT1 -> CAP1 unconditionally.
  - CAP1: capture byte 0 of rdata0/rdata1 into tr/br, then -> VALID.
  - VALID: data_valid=1; outputs held stable. On data_consumed=1, data_valid goes 0 on the next edge and state -> IDLE.
- Latency, counted from the accept edge at T0:
  - data_valid is high at T3 for a non-straddle request, T5 for a straddle request.
  - With a one-cycle consume pulse, a new request can be accepted 2 cycles after data_valid rises.
- data_consumed is ignored outside VALID.
- rd_word_count increments by 2 in each CAP0 and each CAP1 cycle, wrapping at 2^32.
- mem_raddr0/1 hold their last value while IDLE.

Test Plan:
- Preload mem[w] = {4w+3, 4w+2, 4w+1, 4w} (low 8 bits of each) so that pixel(x, y) = (y*64+x) & 0xFF.
- Non-straddle: req x=4, y=2 at T0 -> mem_raddr0=33, mem_raddr1=49; data_valid at T3; tl=0x84, tr=0x85, bl=0xC4, br=0xC5; rd_word_count=2.
- Straddle: req x=7, y=0 -> port0 addresses 1 then 2, port1 addresses 17 then 18; data_valid at T5; tl=0x07, tr=0x08, bl=0x47, br=0x48; rd_word_count +4.
- Clamp: req x=70, y=63, fx=0x40, fy=0x80 -> effective x=62, y=62; tl=0xBE, tr=0xBF, bl=0xFE, br=0xFF; frac_x=0x40, frac_y=0x80.
- Hold: leave data_consumed=0 for 10 cycles while pulsing req_valid -> data_valid and pixels stay stable, req_ready=0, no new address issued; pulse consume -> data_valid=0 next cycle, req_ready=1.
- Back-to-back: 4 requests in requester timing (consume pulse, then req_valid 1 cycle later, mixing straddle and non-straddle) -> all four results correct, no request lost.
- Reset during WAIT1 -> all outputs 0, req_ready=1 immediately after release; next request serviced correctly.

Source files
------------

// File: rtl/quad_pixel_fetch_unit.sv
// quad_pixel_fetch_unit
// Responder side of the 2x2 neighbourhood fetch handshake for the bilinear
// datapath. One request is turned into two (or, when the left and right
// neighbours sit in different words, four) word reads from the dual-port
// 4-pixel-per-word input memory. The four pixels and the fractions are held
// until the requester signals consumption.
module quad_pixel_fetch_unit #(
    parameter int ADDR_W     = 10,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [15:0]       req_xi_base,
    input  logic [15:0]       req_yi_base,
    input  logic [7:0]        req_fx_q,
    input  logic [7:0]        req_fy_q,
    output logic              req_ready,
    output logic              data_valid,
    output logic [7:0]        pixel_tl,
    output logic [7:0]        pixel_tr,
    output logic [7:0]        pixel_bl,
    output logic [7:0]        pixel_br,
    output logic [7:0]        frac_x,
    output logic [7:0]        frac_y,
    input  logic              data_consumed,
    output logic [ADDR_W-1:0] mem_raddr0,
    input  logic [31:0]       mem_rdata0,
    output logic [ADDR_W-1:0] mem_raddr1,
    input  logic [31:0]       mem_rdata1,
    output logic [31:0]       rd_word_count
);

    // Linear pixel index only matters modulo 2^(ADDR_W+2): the word address
    // wraps at 2^ADDR_W and the two low index bits select the byte.
    localparam int IDX_W = ADDR_W + 2;

    // Word stride between row y and row y+1.
    localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(IMG_WIDTH / 4);

    // Largest legal left/top neighbour coordinate.
    localparam logic [15:0] X_MAX = 16'(IMG_WIDTH - 2);
    localparam logic [15:0] Y_MAX = 16'(IMG_HEIGHT - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT0 = 3'd1,
        CAP0  = 3'd2,
        WAIT1 = 3'd3,
        CAP1  = 3'd4,
        VALID = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic [15:0]       x_clamped;
    logic [15:0]       y_clamped;
    logic [ADDR_W-1:0] addr_row0;
    logic [1:0]        x_off;
    logic              straddle;

    // Saturate a coordinate so the 2x2 window never leaves the image.
    function automatic logic [15:0] clamp_coord(input logic [15:0] v,
                                                input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Word address of pixel (x, y): (y*IMG_WIDTH + x) >> 2, wrapped.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] x,
                                                    input logic [15:0] y);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(y) * IDX_W'(IMG_WIDTH) + IDX_W'(x);
        return ADDR_W'(idx >> 2);
    endfunction

    // Pixel k of a 4-pixel word lives in bits [8k+7:8k].
    function automatic logic [7:0] byte_sel(input logic [31:0] w,
                                            input logic [1:0]  k);
        return w[{k, 3'b000} +: 8];
    endfunction

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign x_clamped = clamp_coord(req_xi_base, X_MAX);
    assign y_clamped = clamp_coord(req_yi_base, Y_MAX);
    assign addr_row0 = word_addr(x_clamped, y_clamped);
    assign straddle  = (x_off == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: one read round normally, two when x+1 is in the next word.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = WAIT0;
            WAIT0:   state_next = CAP0;
            CAP0:    state_next = straddle ? WAIT1 : VALID;
            WAIT1:   state_next = CAP1;
            CAP1:    state_next = VALID;
            VALID:   if (data_consumed) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result-valid flag tracks entry to and exit from VALID on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= (state_next == VALID);
        end
    end

    // Request latch: byte offset of the left neighbour and the fractions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_off  <= 2'd0;
            frac_x <= 8'd0;
            frac_y <= 8'd0;
        end else if (accept) begin
            x_off  <= x_clamped[1:0];
            frac_x <= req_fx_q;
            frac_y <= req_fy_q;
        end
    end

    // Read addresses: loaded on accept, stepped to the next word on a straddle,
    // otherwise held (including while idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_raddr0 <= '0;
            mem_raddr1 <= '0;
        end else if (accept) begin
            mem_raddr0 <= addr_row0;
            mem_raddr1 <= addr_row0 + ROW_WORDS;
        end else if (state == CAP0 && straddle) begin
            mem_raddr0 <= mem_raddr0 + ADDR_W'(1);
            mem_raddr1 <= mem_raddr1 + ADDR_W'(1);
        end
    end

    // Pixel capture: left column in CAP0, right column in CAP0 or CAP1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_tl <= 8'd0;
            pixel_tr <= 8'd0;
            pixel_bl <= 8'd0;
            pixel_br <= 8'd0;
        end else if (state == CAP0) begin
            pixel_tl <= byte_sel(mem_rdata0, x_off);
            pixel_bl <= byte_sel(mem_rdata1, x_off);
            if (!straddle) begin
                pixel_tr <= byte_sel(mem_rdata0, x_off + 2'd1);
                pixel_br <= byte_sel(mem_rdata1, x_off + 2'd1);
            end
        end else if (state == CAP1) begin
            pixel_tr <= byte_sel(mem_rdata0, 2'd0);
            pixel_br <= byte_sel(mem_rdata1, 2'd0);
        end
    end

    // Read counter: each capture cycle consumes one word from each port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_count <= 32'd0;
        end else if (state == CAP0 || state == CAP1) begin
            rd_word_count <= rd_word_count + 32'd2;
        end
    end

endmodule

// File: tb/tb_quad_pixel_fetch_unit.sv
// Testbench for quad_pixel_fetch_unit: synchronous dual-port memory model
// preloaded so that pixel(x, y) = (y*64 + x) & 0xFF, a table of requests with
// hand-computed expectations, and a scoreboard queue of expected results.
module tb_quad_pixel_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_xi_base = '0;
    logic [15:0] req_yi_base = '0;
    logic [7:0]  req_fx_q = '0;
    logic [7:0]  req_fy_q = '0;
    logic        req_ready;
    logic        data_valid;
    logic [7:0]  pixel_tl, pixel_tr, pixel_bl, pixel_br;
    logic [7:0]  frac_x, frac_y;
    logic        data_consumed = 1'b0;
    logic [9:0]  mem_raddr0, mem_raddr1;
    logic [31:0] mem_rdata0 = '0;
    logic [31:0] mem_rdata1 = '0;
    logic [31:0] rd_word_count;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_count = 0;

    typedef struct {
        logic [15:0] xi;
        logic [15:0] yi;
        logic [7:0]  fx;
        logic [7:0]  fy;
        logic [9:0]  a0;      // port-0 address right after accept
        logic [9:0]  a0f;     // port-0 address once data_valid is up
        logic [7:0]  tl, tr, bl, br;
        int          lat;     // edge (from accept T0) that first samples data_valid=1
        int          words;   // words read by this request
    } vec_t;

    typedef struct {
        logic [7:0] tl, tr, bl, br, fx, fy;
    } res_t;

    vec_t vecs[8];
    res_t sb_q[$];

    quad_pixel_fetch_unit #(
        .ADDR_W(10), .IMG_WIDTH(64), .IMG_HEIGHT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_xi_base(req_xi_base), .req_yi_base(req_yi_base),
        .req_fx_q(req_fx_q), .req_fy_q(req_fy_q), .req_ready(req_ready),
        .data_valid(data_valid),
        .pixel_tl(pixel_tl), .pixel_tr(pixel_tr), .pixel_bl(pixel_bl), .pixel_br(pixel_br),
        .frac_x(frac_x), .frac_y(frac_y), .data_consumed(data_consumed),
        .mem_raddr0(mem_raddr0), .mem_rdata0(mem_rdata0),
        .mem_raddr1(mem_raddr1), .mem_rdata1(mem_rdata1),
        .rd_word_count(rd_word_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, data one cycle after the address.
    always @(posedge clk) begin
        mem_rdata0 <= mem[mem_raddr0];
        mem_rdata1 <= mem[mem_raddr1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_consume();
        data_consumed = 1'b1;
        @(posedge clk); #1;
        data_consumed = 1'b0;
        check("consume_valid_low", 32'(data_valid), 32'd0);
        check("consume_ready_high", 32'(req_ready), 32'd1);
    endtask

    task automatic run_req(input vec_t v, input bit consume);
        res_t e;
        res_t got;
        int   lat;
        bit   seen;
        check("ready_before_req", 32'(req_ready), 32'd1);
        e.tl = v.tl; e.tr = v.tr; e.bl = v.bl; e.br = v.br; e.fx = v.fx; e.fy = v.fy;
        sb_q.push_back(e);
        req_xi_base = v.xi;
        req_yi_base = v.yi;
        req_fx_q    = v.fx;
        req_fy_q    = v.fy;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("raddr0_accept", 32'(mem_raddr0), 32'(v.a0));
        check("raddr1_accept", 32'(mem_raddr1), 32'(10'(v.a0 + 10'd16)));
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (data_valid) begin
                seen = 1'b1;
                lat  = k + 1;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL data_valid_timeout: got 0 after 20 cycles, expected 1");
        end
        check("latency", 32'(lat), 32'(v.lat));
        exp_count = exp_count + 32'(v.words);
        check("rd_word_count", rd_word_count, exp_count);
        check("raddr0_final", 32'(mem_raddr0), 32'(v.a0f));
        check("raddr1_final", 32'(mem_raddr1), 32'(10'(v.a0f + 10'd16)));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            got.tl = pixel_tl; got.tr = pixel_tr; got.bl = pixel_bl; got.br = pixel_br;
            got.fx = frac_x;   got.fy = frac_y;
            check("pixels", {got.tl, got.tr, got.bl, got.br}, {e.tl, e.tr, e.bl, e.br});
            check("fracs", {16'd0, got.fx, got.fy}, {16'd0, e.fx, e.fy});
        end
        if (consume) do_consume();
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) begin
            mem[w] = {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
        end

        //          xi      yi      fx     fy     a0       a0f      tl     tr     bl     br    lat words
        vecs[0] = '{16'd4,  16'd2,  8'h11, 8'h22, 10'd33,  10'd33,  8'h84, 8'h85, 8'hC4, 8'hC5, 3, 2};
        vecs[1] = '{16'd7,  16'd0,  8'h00, 8'hFF, 10'd1,   10'd2,   8'h07, 8'h08, 8'h47, 8'h48, 5, 4};
        vecs[2] = '{16'd70, 16'd63, 8'h40, 8'h80, 10'd1007,10'd1007,8'hBE, 8'hBF, 8'hFE, 8'hFF, 3, 2};
        vecs[3] = '{16'd3,  16'd5,  8'h01, 8'h02, 10'd80,  10'd81,  8'h43, 8'h44, 8'h83, 8'h84, 5, 4};
        vecs[4] = '{16'd0,  16'd62, 8'hFF, 8'h00, 10'd992, 10'd992, 8'h80, 8'h81, 8'hC0, 8'hC1, 3, 2};
        vecs[5] = '{16'd63, 16'd100,8'h7F, 8'h3C, 10'd1007,10'd1007,8'hBE, 8'hBF, 8'hFE, 8'hFF, 3, 2};
        vecs[6] = '{16'd62, 16'd0,  8'hA5, 8'h5A, 10'd15,  10'd15,  8'h3E, 8'h3F, 8'h7E, 8'h7F, 3, 2};
        vecs[7] = '{16'd11, 16'd61, 8'h33, 8'hCC, 10'd978, 10'd979, 8'h4B, 8'h4C, 8'h8B, 8'h8C, 5, 4};

        // Power-on reset.
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_pixels", {pixel_tl, pixel_tr, pixel_bl, pixel_br}, 32'd0);
        check("reset_fracs", {16'd0, frac_x, frac_y}, 32'd0);
        check("reset_addr", {12'd0, mem_raddr0, mem_raddr1}, 32'd0);
        check("reset_count", rd_word_count, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back table in requester timing.
        for (int i = 0; i < 8; i++) run_req(vecs[i], 1'b1);

        // Hold: result stays put while requests are ignored.
        run_req(vecs[0], 1'b0);
        for (int i = 0; i < 10; i++) begin
            req_valid   = i[0];
            req_xi_base = 16'(i * 5);
            req_yi_base = 16'(i);
            @(posedge clk); #1;
            check("hold_valid", 32'(data_valid), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_pixels", {pixel_tl, pixel_tr, pixel_bl, pixel_br}, 32'h8485C4C5);
            check("hold_addr", 32'(mem_raddr0), 32'd33);
        end
        req_valid = 1'b0;
        do_consume();

        // Reset while a straddle request waits for its second word.
        req_xi_base = 16'd7;
        req_yi_base = 16'd0;
        req_fx_q    = 8'h12;
        req_fy_q    = 8'h34;
        req_valid   = 1'b1;
        @(posedge clk); #1;      // accepted -> WAIT0
        req_valid = 1'b0;
        @(posedge clk); #1;      // CAP0
        @(posedge clk); #1;      // WAIT1
        check("pre_reset_in_flight", 32'(pixel_tl), 32'h07);
        rst_n = 1'b0;
        #2;
        check("midreset_valid", 32'(data_valid), 32'd0);
        check("midreset_pixels", {pixel_tl, pixel_tr, pixel_bl, pixel_br}, 32'd0);
        check("midreset_fracs", {16'd0, frac_x, frac_y}, 32'd0);
        check("midreset_addr", {12'd0, mem_raddr0, mem_raddr1}, 32'd0);
        check("midreset_count", rd_word_count, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(req_ready), 32'd1);
        exp_count = 32'd0;
        sb_q.delete();
        @(posedge clk); #1;
        check("post_reset_no_valid", 32'(data_valid), 32'd0);
        run_req(vecs[1], 1'b1);
        run_req(vecs[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
